// File: rtl/dequantize_stream_if.sv
// Valid/ready stream bundle for dequantize_stream: 8-bit lanes in, 32-bit lanes out.
interface dequantize_stream_if #(
  parameter int SIZE = 1
);
  logic [8*SIZE-1:0]  pixel_in;
  logic               in_valid;
  logic               in_ready;
  logic [32*SIZE-1:0] pixel_out;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output pixel_in, in_valid, out_ready,
    input  in_ready, pixel_out, out_valid
  );

  modport slave (
    input  pixel_in, in_valid, out_ready,
    output in_ready, pixel_out, out_valid
  );
endinterface

// File: rtl/dequantize_stream.sv
// Two-stage streaming dequantizer: per lane (q8 - ZERO_POINT) * 2^SHIFT, rounded on right shifts.
// Define DEQUANTIZE_SAT_EN to saturate left-shift overflow instead of wrapping to 32 bits.
module dequantize_stream #(
  parameter int SHIFT      = 0,
  parameter int SIZE       = 1,
  parameter int ZERO_POINT = 0
) (
  input  logic               clock,
  input  logic               reset,
  dequantize_stream_if.slave bus
);

  localparam int LSH = (SHIFT > 0) ? SHIFT : 0;
  localparam int RSH = (SHIFT < 0) ? -SHIFT : 0;
  // Half-LSB rounding bias; collapses to zero when there is no right shift.
  localparam logic signed [39:0] RND = (40'sd1 <<< RSH) >>> 1;
  localparam logic [7:0]         ZP8 = ZERO_POINT[7:0];
  localparam logic signed [9:0]  ZP  = {{2{ZP8[7]}}, ZP8};
`ifdef DEQUANTIZE_SAT_EN
  localparam logic signed [39:0] MAX32 = 40'sh00_7FFF_FFFF;
  localparam logic signed [39:0] MIN32 = -40'sh00_8000_0000;
`endif

  logic                     s1_valid;
  logic                     s2_valid;
  logic signed [9:0]        s1_data [SIZE];
  logic [32*SIZE-1:0]       s2_data;
  logic [32*SIZE-1:0]       scaled;
  logic                     in_ready_c;
  logic                     in_fire;
  logic                     s2_load;

  function automatic logic [31:0] scale(input logic signed [9:0] d);
    logic signed [39:0] w;
    w = $signed({{30{d[9]}}, d});
    w = ((w <<< LSH) + RND) >>> RSH;
`ifdef DEQUANTIZE_SAT_EN
    if (w > MAX32) return 32'h7FFF_FFFF;
    if (w < MIN32) return 32'h8000_0000;
`endif
    return w[31:0];
  endfunction

  always_comb begin
    scaled = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      scaled[32*i +: 32] = scale(s1_data[i]);
    end
  end

  assign in_ready_c = !reset && (!s1_valid || !s2_valid || bus.out_ready);
  assign in_fire    = bus.in_valid && in_ready_c;
  assign s2_load    = s1_valid && (!s2_valid || bus.out_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        s1_data[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        for (int unsigned i = 0; i < SIZE; i++) begin
          s1_data[i] <= $signed({{2{bus.pixel_in[8*i+7]}}, bus.pixel_in[8*i +: 8]}) - ZP;
        end
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_data  <= scaled;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid;
  assign bus.pixel_out = s2_data;

endmodule
